// File: rtl/inst_fetch_pkg.sv
//------------------------------------------------------------------------------
// Module : inst_fetch_pkg
// Brief  : Shared word width, NOP encoding and fetch FSM states.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package inst_fetch_pkg;

  localparam int WORD = 32;
  localparam logic [WORD-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_BEAT = 2'd1,
    FS_DONE = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/inst_fetch.sv
//------------------------------------------------------------------------------
// Module : inst_fetch
// Brief  : Byte-serial big-endian instruction fetch with a single-entry
//          last-fetch tag, bus timeout and misalignment reporting.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk_cpu,
  input  logic            reset,
  input  logic [WORD-1:0] pc,
  input  logic            fetch_req,
  input  logic            inval,
  output logic [WORD-1:0] inst,
  output logic            inst_valid,
  output logic            fetch_err,
  output logic            busy,
  output logic [WORD-1:0] mem_addr,
  output logic            mem_req,
  input  logic            mem_ack,
  input  logic [7:0]      mem_rdata
);

  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [WORD-1:0] r_pc_lat;
  logic [1:0]      r_beat;
  logic [7:0]      r_tmo;
  logic [23:0]     r_asm;
  logic [WORD-1:0] r_inst;
  logic            r_err;
  logic [WORD-1:0] r_tag;
  logic            r_tag_valid;

  logic            w_misalign;
  logic            w_hit;
  logic            w_last_ack;
  logic            w_timeout;

  assign w_misalign = (pc[1:0] != 2'b00);
  assign w_hit      = r_tag_valid && (pc == r_tag) && !inval;
  assign w_last_ack = mem_ack && (r_beat == 2'd3);
  assign w_timeout  = !mem_ack && (r_tmo == c_TMO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FS_IDLE: begin
        if (fetch_req) begin
          w_state_nxt = (w_misalign || w_hit) ? FS_DONE : FS_BEAT;
        end
      end
      FS_BEAT: begin
        if (w_last_ack || w_timeout) begin
          w_state_nxt = FS_DONE;
        end
      end
      FS_DONE: w_state_nxt = FS_IDLE;
      default: w_state_nxt = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      r_state     <= FS_IDLE;
      r_pc_lat    <= '0;
      r_beat      <= 2'd0;
      r_tmo       <= 8'd0;
      r_asm       <= 24'd0;
      r_inst      <= NOP_INST;
      r_err       <= 1'b0;
      r_tag       <= '0;
      r_tag_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        FS_IDLE: begin
          if (fetch_req) begin
            if (w_misalign) begin
              r_inst <= NOP_INST;
              r_err  <= 1'b1;
            end else if (w_hit) begin
              r_err <= 1'b0;
            end else begin
              r_pc_lat <= pc;
              r_beat   <= 2'd0;
              r_tmo    <= 8'd0;
            end
          end
        end
        FS_BEAT: begin
          if (mem_ack) begin
            // Bytes arrive most-significant first; the last one completes the word.
            r_asm  <= {r_asm[15:0], mem_rdata};
            r_beat <= r_beat + 2'd1;
            r_tmo  <= 8'd0;
            if (w_last_ack) begin
              r_inst      <= {r_asm, mem_rdata};
              r_err       <= 1'b0;
              r_tag       <= r_pc_lat;
              r_tag_valid <= 1'b1;
            end
          end else begin
            r_tmo <= r_tmo + 8'd1;
            if (w_timeout) begin
              r_inst      <= NOP_INST;
              r_err       <= 1'b1;
              r_tag_valid <= 1'b0;
            end
          end
        end
        default: ;
      endcase
      // Invalidation overrides any tag update made in the same cycle.
      if (inval) begin
        r_tag_valid <= 1'b0;
      end
    end
  end

  assign inst       = r_inst;
  assign inst_valid = (r_state == FS_DONE);
  assign fetch_err  = inst_valid && r_err;
  assign busy       = (r_state != FS_IDLE);
  assign mem_req    = (r_state == FS_BEAT);
  assign mem_addr   = r_pc_lat + {30'd0, r_beat};

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
//------------------------------------------------------------------------------
// Module : tb_inst_fetch
// Brief  : Scoreboard bench for inst_fetch with a byte-wide memory responder.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int TMO    = 4;
  localparam int NEVER  = 1000;
  localparam int N_RAND = 250;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk_cpu = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        fetch_req;
  logic        inval;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_err;
  logic        busy;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  bit          noisy = 1'b0;

  exp_t        sb_q[$];
  logic [31:0] addr_q[$];
  int          wait_q[$];

  logic [31:0] m_tag = 32'h0;
  logic        m_tag_v = 1'b0;
  logic [31:0] m_inst = 32'h0;
  logic [31:0] held_inst = 32'h0;

  inst_fetch #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_cpu   (clk_cpu),
    .reset     (reset),
    .pc        (pc),
    .fetch_req (fetch_req),
    .inval     (inval),
    .inst      (inst),
    .inst_valid(inst_valid),
    .fetch_err (fetch_err),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk_cpu = ~clk_cpu;
  always @(posedge clk_cpu) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E37_79B1;
    case (a)
      32'h100: return 8'h8C;
      32'h101: return 8'hA2;
      32'h102: return 8'h00;
      32'h103: return 8'h04;
      default: return h[31:24];
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {mem_byte(a), mem_byte(a + 32'd1), mem_byte(a + 32'd2), mem_byte(a + 32'd3)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk_cpu);
    #1;
  endtask

  // Issues one request, predicts its outcome and keeps the bus quiet or noisy until done.
  task automatic do_fetch(input logic [31:0] a, input logic inv,
                          input int w0, input int w1, input int w2, input int w3);
    int   w[4];
    int   c;
    int   t;
    exp_t e;
    logic miss_ok;
    w = '{w0, w1, w2, w3};
    wait_cycle();
    c = cyc;
    pc = a;
    fetch_req = 1'b1;
    inval = inv;
    miss_ok = 1'b0;
    if (a[1:0] != 2'b00) begin
      e.inst = 32'h0; e.err = 1'b1; e.cyc = c + 1;
      if (inv) m_tag_v = 1'b0;
    end else if (m_tag_v && m_tag == a && !inv) begin
      e.inst = m_inst; e.err = 1'b0; e.cyc = c + 1;
    end else begin
      t = c + 1;
      e.inst = 32'h0; e.err = 1'b1;
      for (int k = 0; k < 4; k++) begin
        wait_q.push_back(w[k]);
        addr_q.push_back(a + 32'(k));
        if (w[k] == NEVER) begin
          t += TMO;
          break;
        end
        t += 1 + w[k];
        if (k == 3) begin
          e.inst = exp_word(a); e.err = 1'b0; miss_ok = 1'b1;
        end
      end
      e.cyc = t;
      m_tag_v = miss_ok;
      if (miss_ok) m_tag = a;
    end
    m_inst = e.inst;
    sb_q.push_back(e);
    @(negedge clk_cpu);
    chk("busy_at_req", 32'(busy), 32'd0);
    for (int t2 = c + 1; t2 <= e.cyc; t2++) begin
      wait_cycle();
      if (noisy) begin
        fetch_req = 1'($urandom % 2);
        pc = $urandom;
        inval = (t2 == e.cyc - 1) ? 1'b0 : 1'($urandom % 4 == 0);
      end else begin
        fetch_req = 1'b0;
        inval = 1'b0;
      end
      if (t2 == e.cyc && inval) m_tag_v = 1'b0;
    end
    if (miss_ok) chk("beats_consumed", 32'(addr_q.size()), 32'd0);
    addr_q.delete();
    wait_q.delete();
  endtask

  // Memory responder: follows the per-beat wait plan and checks each beat address.
  initial begin
    int wleft;
    wleft = -1;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    wait (mon_en);
    forever begin
      wait_cycle();
      mem_ack = 1'b0;
      mem_rdata = 8'($urandom);
      if (mem_req === 1'b1) begin
        if (addr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL mem_req_unexpected: got mem_req=1 addr %h, required mem_req=0 (cycle %0d)", mem_addr, cyc);
        end else begin
          chk("mem_addr", mem_addr, addr_q[0]);
          if (wleft < 0) wleft = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
          if (wleft == 0) begin
            mem_ack = 1'b1;
            mem_rdata = mem_byte(mem_addr);
            void'(addr_q.pop_front());
            wleft = -1;
          end else if (wleft != NEVER) begin
            wleft--;
          end
        end
      end else begin
        wleft = -1;
        mem_ack = 1'($urandom % 4 == 0);
      end
    end
  end

  // Output monitor: pops the scoreboard whenever the DUT strobes a result.
  initial begin
    exp_t e;
    wait (mon_en);
    forever begin
      @(negedge clk_cpu);
      if (reset) continue;
      if (inst_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_valid: got inst_valid=1 inst %h, required no result (cycle %0d)", inst, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("inst", inst, e.inst);
          chk("fetch_err", 32'(fetch_err), 32'(e.err));
          chk("valid_cycle", 32'(cyc), 32'(e.cyc));
          chk("busy_at_valid", 32'(busy), 32'd1);
          held_inst = e.inst;
        end
      end else begin
        chk("inst_hold", inst, held_inst);
        chk("err_idle", 32'(fetch_err), 32'd0);
        if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
          e = sb_q.pop_front();
          n_vec++; n_err++;
          $display("FAIL missing_valid: got no inst_valid, required one in cycle %0d (now %0d)", e.cyc, cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] last_a;
    int          w[4];
    int          c;
    reset = 1'b1; fetch_req = 1'b0; inval = 1'b0; pc = 32'h0;
    repeat (3) wait_cycle();
    @(negedge clk_cpu);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    wait_cycle();
    reset = 1'b0;
    mon_en = 1'b1;

    do_fetch(32'h100, 1'b0, 0, 0, 0, 0);
    do_fetch(32'h100, 1'b0, 0, 0, 0, 0);
    do_fetch(32'h100, 1'b1, 0, 0, 0, 0);
    do_fetch(32'h100, 1'b1, 0, 2, 0, 0);
    do_fetch(32'h200, 1'b0, NEVER, 0, 0, 0);
    do_fetch(32'h102, 1'b0, 0, 0, 0, 0);
    do_fetch(32'h100, 1'b0, 0, 0, 0, 0);

    noisy = 1'b1;
    last_a = 32'h100;
    for (int i = 0; i < N_RAND; i++) begin
      repeat ($urandom % 3) begin
        wait_cycle();
        fetch_req = 1'b0;
        inval = 1'($urandom % 4 == 0);
        if (inval) m_tag_v = 1'b0;
      end
      case ($urandom % 8)
        0, 1, 2: a = last_a;
        3:       a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
        4:       a = 32'h100;
        default: a = $urandom & 32'hFFFF_FFFC;
      endcase
      for (int k = 0; k < 4; k++) w[k] = $urandom % 3;
      if ($urandom % 10 == 0) w[$urandom % 4] = NEVER;
      do_fetch(a, 1'($urandom % 4 == 0), w[0], w[1], w[2], w[3]);
      if (a[1:0] == 2'b00) last_a = a;
    end
    noisy = 1'b0;

    // Reset arriving in the second beat cycle of a miss.
    wait_cycle();
    fetch_req = 1'b0; inval = 1'b0;
    wait_cycle();
    c = cyc;
    pc = 32'h0000_0400; fetch_req = 1'b1; inval = 1'b1;
    m_tag_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      addr_q.push_back(32'h400 + 32'(k));
      wait_q.push_back(0);
    end
    wait_cycle();
    fetch_req = 1'b0; inval = 1'b0;
    wait_cycle();
    reset = 1'b1;
    wait_cycle();
    reset = 1'b0;
    addr_q.delete(); wait_q.delete();
    m_inst = 32'h0; held_inst = 32'h0; m_tag_v = 1'b0;
    @(negedge clk_cpu);
    chk("midrst_cycle", 32'(cyc), 32'(c + 3));
    chk("midrst_inst", inst, 32'h0);
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_err", 32'(fetch_err), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    do_fetch(32'h400, 1'b0, 0, 0, 0, 0);

    repeat (5) wait_cycle();
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
